// File: rtl/multi_alarm_clock.sv
// 24-hour, 7-day time-of-day counter with NUM_ALARMS independently armed,
// day-masked alarms, each with its own snooze and ring auto-timeout.
module multi_alarm_clock #(
    parameter int NUM_ALARMS       = 4,
    parameter int SNOOZE_MIN       = 9,
    parameter int RING_TIMEOUT_MIN = 5,
    parameter int AW               = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  timeset,
    input  logic                  alarmset,
    input  logic [AW-1:0]         alarm_sel,
    input  logic                  minadv,
    input  logic                  hrsadv,
    input  logic                  dayadv,
    input  logic                  mask_wr,
    input  logic [6:0]            mask_in,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic                  snooze,
    input  logic                  stop,
    output logic [5:0]            tsec,
    output logic [5:0]            tmin,
    output logic [4:0]            thrs,
    output logic [2:0]            tday,
    output logic [5:0]            disp_min,
    output logic [4:0]            disp_hrs,
    output logic                  buzz,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic [NUM_ALARMS-1:0] snoozing
);
    typedef enum logic [1:0] {IDLE, RING, SNOOZE} alarm_state_e;

    localparam logic [5:0] SNOOZE_CNT = 6'(SNOOZE_MIN);
    localparam logic [5:0] RING_CNT   = 6'(RING_TIMEOUT_MIN);

    logic [5:0]   sec_q, sec_d, min_q, min_d;
    logic [4:0]   hrs_q, hrs_d;
    logic [2:0]   day_q, day_d;
    logic         sec_strobe_q;
    logic [5:0]   amin_q  [NUM_ALARMS];
    logic [5:0]   amin_d  [NUM_ALARMS];
    logic [4:0]   ahrs_q  [NUM_ALARMS];
    logic [4:0]   ahrs_d  [NUM_ALARMS];
    logic [6:0]   mask_q  [NUM_ALARMS];
    logic [6:0]   mask_d  [NUM_ALARMS];
    alarm_state_e state_q [NUM_ALARMS];
    alarm_state_e state_d [NUM_ALARMS];
    logic [5:0]   cnt_q   [NUM_ALARMS];
    logic [5:0]   cnt_d   [NUM_ALARMS];

    logic [5:0] sec_inc, min_inc;
    logic [4:0] hrs_inc;
    logic [2:0] day_inc;
    logic       sel_ok, edit_alarm, minute_evt;

    assign sec_inc    = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
    assign min_inc    = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
    assign hrs_inc    = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
    assign day_inc    = (day_q == 3'd6)  ? 3'd0 : day_q + 3'd1;
    assign sel_ok     = int'(alarm_sel) < NUM_ALARMS;
    assign edit_alarm = tick && alarmset && !timeset && sel_ok;
    assign minute_evt = sec_strobe_q && (sec_q == 6'd0);

    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
        sec_d = sec_q;
        min_d = min_q;
        hrs_d = hrs_q;
        day_d = day_q;
        if (tick) begin
            sec_d = sec_inc;
            if (timeset) begin
                if (minadv) min_d = min_inc;
                if (hrsadv) hrs_d = hrs_inc;
                if (dayadv) day_d = day_inc;
            end else if (sec_q == 6'd59) begin
                min_d = min_inc;
                if (min_q == 6'd59) begin
                    hrs_d = hrs_inc;
                    if (hrs_q == 5'd23) day_d = day_inc;
                end
            end
        end
    end

    always_comb begin
        amin_d = amin_q;
        ahrs_d = ahrs_q;
        mask_d = mask_q;
        if (edit_alarm) begin
            if (minadv) amin_d[alarm_sel] = (amin_q[alarm_sel] == 6'd59) ? 6'd0 : amin_q[alarm_sel] + 6'd1;
            if (hrsadv) ahrs_d[alarm_sel] = (ahrs_q[alarm_sel] == 5'd23) ? 5'd0 : ahrs_q[alarm_sel] + 5'd1;
        end
        if (mask_wr && sel_ok) mask_d[alarm_sel] = mask_in;
    end

    // Priority per alarm: disarm > stop > snooze > minute timer / trigger.
    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (!alarm_en[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (minute_evt && !timeset && min_q == amin_q[i] &&
                            hrs_q == ahrs_q[i] && mask_q[i][day_q]) begin
                            state_d[i] = RING;
                            cnt_d[i]   = RING_CNT;
                        end
                    end
                    RING: begin
                        if (stop) begin
                            state_d[i] = IDLE;
                        end else if (snooze) begin
                            state_d[i] = SNOOZE;
                            cnt_d[i]   = SNOOZE_CNT;
                        end else if (minute_evt) begin
                            if (cnt_q[i] == 6'd1) state_d[i] = IDLE;
                            cnt_d[i] = cnt_q[i] - 6'd1;
                        end
                    end
                    SNOOZE: begin
                        if (stop) begin
                            state_d[i] = IDLE;
                        end else if (minute_evt) begin
                            if (cnt_q[i] == 6'd1) begin
                                state_d[i] = RING;
                                cnt_d[i]   = RING_CNT;
                            end else begin
                                cnt_d[i] = cnt_q[i] - 6'd1;
                            end
                        end
                    end
                    default: state_d[i] = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_q        <= '0;
            min_q        <= '0;
            hrs_q        <= '0;
            day_q        <= '0;
            sec_strobe_q <= 1'b0;
            // NOTE: the alarm register file has defined power-on values, so it is reset like any other flop.
            for (int i = 0; i < NUM_ALARMS; i++) begin
                amin_q[i]  <= '0;
                ahrs_q[i]  <= '0;
                mask_q[i]  <= 7'h7F;
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every flop load from pre-edge values.
            sec_q        <= sec_d;
            min_q        <= min_d;
            hrs_q        <= hrs_d;
            day_q        <= day_d;
            sec_strobe_q <= tick;
            amin_q       <= amin_d;
            ahrs_q       <= ahrs_d;
            mask_q       <= mask_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        disp_min = min_q;
        disp_hrs = hrs_q;
        if (alarmset && !timeset) begin
            disp_min = sel_ok ? amin_q[alarm_sel] : 6'd0;
            disp_hrs = sel_ok ? ahrs_q[alarm_sel] : 5'd0;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            ringing[i]  = (state_q[i] == RING);
            snoozing[i] = (state_q[i] == SNOOZE);
        end
    end

    assign buzz = |ringing;
    assign tsec = sec_q;
    assign tmin = min_q;
    assign thrs = hrs_q;
    assign tday = day_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Bench for multi_alarm_clock: directed scenarios plus randomized traffic, all
// checked each cycle against a seconds-of-week / minute-deadline reference model.
module tb_multi_alarm_clock;
    localparam int N  = 4;
    localparam int SN = 9;
    localparam int RT = 5;

    logic         clk = 1'b0;
    logic         rst, tick, timeset, alarmset, minadv, hrsadv, dayadv, mask_wr, snooze, stop;
    logic [1:0]   alarm_sel;
    logic [6:0]   mask_in;
    logic [N-1:0] alarm_en;
    logic [5:0]   tsec, tmin, disp_min;
    logic [4:0]   thrs, disp_hrs;
    logic [2:0]   tday;
    logic         buzz;
    logic [N-1:0] ringing, snoozing;

    always #5 clk = ~clk;

    multi_alarm_clock #(.NUM_ALARMS(N), .SNOOZE_MIN(SN), .RING_TIMEOUT_MIN(RT)) dut (
        .clk(clk), .rst(rst), .tick(tick), .timeset(timeset), .alarmset(alarmset),
        .alarm_sel(alarm_sel), .minadv(minadv), .hrsadv(hrsadv), .dayadv(dayadv),
        .mask_wr(mask_wr), .mask_in(mask_in), .alarm_en(alarm_en), .snooze(snooze),
        .stop(stop), .tsec(tsec), .tmin(tmin), .thrs(thrs), .tday(tday),
        .disp_min(disp_min), .disp_hrs(disp_hrs), .buzz(buzz), .ringing(ringing),
        .snoozing(snoozing)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: wall time as fields, alarms as absolute minute-event deadlines.
    int       m_sec, m_min, m_hrs, m_day, m_mc;
    bit       m_strobe;
    int       m_amin [N];
    int       m_ahrs [N];
    bit [6:0] m_mask [N];
    int       m_ring_end [N];
    int       m_wake_at [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sec = 0; m_min = 0; m_hrs = 0; m_day = 0; m_mc = 0; m_strobe = 0;
        for (int i = 0; i < N; i++) begin
            m_amin[i] = 0; m_ahrs[i] = 0; m_mask[i] = 7'h7F;
            m_ring_end[i] = -1; m_wake_at[i] = -1;
        end
    endtask

    task automatic model_edge();
        int t, mc_n;
        bit evt;
        int nr [N];
        int nw [N];
        evt  = m_strobe && (m_sec == 0);
        mc_n = m_mc + (evt ? 1 : 0);
        for (int i = 0; i < N; i++) begin
            nr[i] = m_ring_end[i];
            nw[i] = m_wake_at[i];
            if (!alarm_en[i]) begin
                nr[i] = -1; nw[i] = -1;
            end else if (m_ring_end[i] >= 0) begin
                if (stop) nr[i] = -1;
                else if (snooze) begin nr[i] = -1; nw[i] = mc_n + SN; end
                else if (evt && mc_n == m_ring_end[i]) nr[i] = -1;
            end else if (m_wake_at[i] >= 0) begin
                if (stop) nw[i] = -1;
                else if (evt && mc_n == m_wake_at[i]) begin nw[i] = -1; nr[i] = mc_n + RT; end
            end else if (evt && !timeset && m_min == m_amin[i] && m_hrs == m_ahrs[i] && m_mask[i][m_day]) begin
                nr[i] = mc_n + RT;
            end
        end
        if (int'(alarm_sel) < N) begin
            if (tick && alarmset && !timeset) begin
                if (minadv) m_amin[alarm_sel] = (m_amin[alarm_sel] + 1) % 60;
                if (hrsadv) m_ahrs[alarm_sel] = (m_ahrs[alarm_sel] + 1) % 24;
            end
            if (mask_wr) m_mask[alarm_sel] = mask_in;
        end
        if (tick) begin
            if (timeset) begin
                m_sec = (m_sec + 1) % 60;
                if (minadv) m_min = (m_min + 1) % 60;
                if (hrsadv) m_hrs = (m_hrs + 1) % 24;
                if (dayadv) m_day = (m_day + 1) % 7;
            end else begin
                t = (((m_day * 24 + m_hrs) * 60 + m_min) * 60 + m_sec + 1) % (7 * 86400);
                m_sec = t % 60;
                m_min = (t / 60) % 60;
                m_hrs = (t / 3600) % 24;
                m_day = t / 86400;
            end
        end
        m_strobe = tick;
        m_mc = mc_n;
        for (int i = 0; i < N; i++) begin
            m_ring_end[i] = nr[i];
            m_wake_at[i]  = nw[i];
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] er, es;
        int dm, dh;
        for (int i = 0; i < N; i++) begin
            er[i] = (m_ring_end[i] >= 0);
            es[i] = (m_wake_at[i] >= 0);
        end
        dm = m_min;
        dh = m_hrs;
        if (alarmset && !timeset) begin
            dm = m_amin[alarm_sel];
            dh = m_ahrs[alarm_sel];
        end
        check("tsec", 32'(tsec), m_sec);
        check("tmin", 32'(tmin), m_min);
        check("thrs", 32'(thrs), m_hrs);
        check("tday", 32'(tday), m_day);
        check("disp_min", 32'(disp_min), dm);
        check("disp_hrs", 32'(disp_hrs), dh);
        check("ringing", 32'(ringing), 32'(er));
        check("snoozing", 32'(snoozing), 32'(es));
        check("buzz", 32'(buzz), 32'(|er));
    endtask

    task automatic step(input logic t);
        tick = t;
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
        tick = 1'b0; stop = 1'b0; snooze = 1'b0; mask_wr = 1'b0;
    endtask

    task automatic set_time(input int d, input int h, input int m, input int s);
        int k;
        k = 0;
        timeset = 1'b1;
        alarmset = 1'b0;
        while (!(m_day == d && m_hrs == h && m_min == m && m_sec == s) && k < 400) begin
            minadv = (m_min != m);
            hrsadv = (m_hrs != h);
            dayadv = (m_day != d);
            step(1'b1);
            k++;
        end
        check("set_time_bound", 32'(k < 400), 32'd1);
        timeset = 1'b0; minadv = 1'b0; hrsadv = 1'b0; dayadv = 1'b0;
    endtask

    task automatic set_alarm(input int a, input int h, input int m);
        int k;
        k = 0;
        timeset = 1'b0;
        alarmset = 1'b1;
        alarm_sel = 2'(a);
        while (!(m_ahrs[a] == h && m_amin[a] == m) && k < 200) begin
            minadv = (m_amin[a] != m);
            hrsadv = (m_ahrs[a] != h);
            step(1'b1);
            k++;
        end
        check("set_alarm_bound", 32'(k < 200), 32'd1);
        alarmset = 1'b0; minadv = 1'b0; hrsadv = 1'b0;
    endtask

    task automatic write_mask(input int a, input logic [6:0] mk);
        alarm_sel = 2'(a);
        mask_in = mk;
        mask_wr = 1'b1;
        step(1'b0);
    endtask

    task automatic tick_until(input int h, input int m, input int s);
        int k;
        k = 0;
        while (!(m_hrs == h && m_min == m && m_sec == s) && k < 5000) begin
            step(1'b1);
            k++;
        end
        check("tick_until_bound", 32'(k < 5000), 32'd1);
    endtask

    initial begin
        int ai, rh, rm, rd;
        logic [6:0] mk;

        rst = 1'b0; tick = 1'b0; timeset = 1'b0; alarmset = 1'b0; alarm_sel = '0;
        minadv = 1'b0; hrsadv = 1'b0; dayadv = 1'b0; mask_wr = 1'b0; mask_in = '0;
        alarm_en = '0; snooze = 1'b0; stop = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0);

        // Asynchronous reset from 13:45:30 day 3.
        set_time(3, 13, 45, 30);
        #2;
        rst = 1'b0;
        #1;
        check("rst_tsec", 32'(tsec), 32'd0);
        check("rst_tmin", 32'(tmin), 32'd0);
        check("rst_thrs", 32'(thrs), 32'd0);
        check("rst_tday", 32'(tday), 32'd0);
        check("rst_buzz", 32'(buzz), 32'd0);
        check("rst_ringing", 32'(ringing), 32'd0);
        check("rst_snoozing", 32'(snoozing), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0);

        // Week rollover; alarm3 left at reset 00:00 / mask 7F fires on day 0.
        set_time(6, 23, 59, 58);
        alarm_en = 4'b1000;
        step(1'b1);
        step(1'b1);
        check("roll_sec", 32'(tsec), 32'd0);
        check("roll_min", 32'(tmin), 32'd0);
        check("roll_hrs", 32'(thrs), 32'd0);
        check("roll_day", 32'(tday), 32'd0);
        step(1'b0);
        check("reset_mask_fires", 32'(ringing), 32'b1000);
        stop = 1'b1;
        step(1'b0);
        check("stop_a3", 32'(buzz), 32'd0);
        alarm_en = '0;

        // Alarm0 07:30 weekdays-only mask, snooze and timeout.
        set_alarm(0, 7, 30);
        write_mask(0, 7'b0011111);
        alarm_en = 4'b0001;
        set_time(2, 7, 29, 59);
        step(1'b1);
        check("a0_not_yet", 32'(ringing[0]), 32'd0);
        step(1'b0);
        check("a0_ring_day2", 32'(ringing[0]), 32'd1);
        snooze = 1'b1;
        step(1'b0);
        check("a0_snooze", 32'(snoozing[0]), 32'd1);
        tick_until(7, 39, 0);
        step(1'b0);
        check("a0_resnooze_ring", 32'(ringing[0]), 32'd1);
        tick_until(7, 44, 0);
        step(1'b0);
        check("a0_timeout", 32'({ringing[0], snoozing[0]}), 32'd0);
        set_time(5, 7, 29, 59);
        step(1'b1);
        step(1'b0);
        check("a0_day5_masked", 32'(ringing[0]), 32'd0);
        alarm_en = '0;

        // Alarms 1..3 at 06:00: group snooze, disarm, group stop.
        set_alarm(1, 6, 0);
        set_alarm(2, 6, 0);
        set_alarm(3, 6, 0);
        alarm_en = 4'b1110;
        set_time(1, 5, 59, 59);
        step(1'b1);
        step(1'b0);
        check("a123_ring", 32'(ringing), 32'b1110);
        snooze = 1'b1;
        step(1'b0);
        check("a123_snooze", 32'(snoozing), 32'b1110);
        alarm_en = 4'b0110;
        step(1'b0);
        check("a3_disarm", 32'(snoozing), 32'b0110);
        tick_until(6, 9, 0);
        step(1'b0);
        check("a12_rering", 32'(ringing), 32'b0110);
        stop = 1'b1;
        step(1'b0);
        check("stop_all", 32'(ringing), 32'd0);
        alarm_en = '0;

        // Time-set: seconds keep running, no carry, and no trigger.
        set_time(0, 8, 59, 59);
        timeset = 1'b1; minadv = 1'b1; hrsadv = 1'b1;
        repeat (3) step(1'b1);
        check("ts_sec", 32'(tsec), 32'd2);
        check("ts_min", 32'(tmin), 32'd2);
        check("ts_hrs", 32'(thrs), 32'd11);
        timeset = 1'b0; minadv = 1'b0; hrsadv = 1'b0;
        set_alarm(0, 9, 2);
        write_mask(0, 7'h7F);
        alarm_en = 4'b0001;
        set_time(0, 9, 1, 59);
        timeset = 1'b1; minadv = 1'b1;
        step(1'b1);
        minadv = 1'b0;
        step(1'b0);
        check("ts_no_trigger", 32'(ringing[0]), 32'd0);
        timeset = 1'b0;
        alarm_en = '0;

        // Randomized alarm/day/mask triggers.
        for (int r = 0; r < 4; r++) begin
            ai = $urandom_range(0, 3);
            rh = $urandom_range(0, 23);
            rm = $urandom_range(1, 59);
            rd = $urandom_range(0, 6);
            mk = 7'($urandom);
            alarm_en = '0;
            set_alarm(ai, rh, rm);
            write_mask(ai, mk);
            alarm_en = 4'(1 << ai);
            set_time(rd, rh, rm - 1, 59);
            step(1'b1);
            step(1'b0);
            check("rand_ring", 32'(ringing[ai]), 32'(mk[rd]));
            snooze = 1'($urandom_range(0, 1));
            step(1'b0);
            stop = 1'b1;
            step(1'b0);
        end

        // Randomized free-running traffic.
        alarm_en = 4'($urandom);
        for (int c = 0; c < 1500; c++) begin
            timeset   = ($urandom_range(0, 7) == 0);
            alarmset  = ($urandom_range(0, 3) == 0);
            alarm_sel = 2'($urandom_range(0, 3));
            minadv    = 1'($urandom_range(0, 1));
            hrsadv    = 1'($urandom_range(0, 1));
            dayadv    = 1'($urandom_range(0, 1));
            mask_in   = 7'($urandom);
            mask_wr   = ($urandom_range(0, 15) == 0);
            snooze    = ($urandom_range(0, 15) == 0);
            stop      = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 63) == 0) alarm_en = 4'($urandom);
            step(1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
